// File: rtl/ringbuf_param.sv
// ringbuf_param: serial-in / serial-out circular word buffer.
//   txda/txen are deserialised into DATA_WIDTH-bit words and stored in a
//   DEPTH-entry ring. Stored words are re-serialised onto rxda with txc
//   framing and an outstrobe on the final slot, paced by rx_ready.
// Build option: define RINGBUF_PARITY_EN to append an even-parity slot to
//   every outgoing word. The default build has no parity slot.
module ringbuf_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int AFULL_LVL  = DEPTH - 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     txda,
  input  logic                     txen,
  input  logic                     rx_ready,
  output logic                     rxda,
  output logic                     txc,
  output logic                     outstrobe,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_WIDTH);
`ifdef RINGBUF_PARITY_EN
  localparam int SLOTS = DATA_WIDTH + 1;
`else
  localparam int SLOTS = DATA_WIDTH;
`endif
  localparam int SW = $clog2(SLOTS);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_reg, state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;

  // Only the bits received before the last one need storing.
  logic [DATA_WIDTH-2:0] in_sr_reg;
  logic [DATA_WIDTH-1:0] in_word;
  logic [BW-1:0]         in_bit_reg;
  logic                  in_last, wr_req, wr_ok;

  logic [DATA_WIDTH-1:0] out_sr_reg;
  logic [SW-1:0]         slot_reg;
  logic                  last_slot, pop, advance, cur_bit;

  logic [CW-1:0]         count_next;

  // Word assembled from the stored bits plus the bit arriving this cycle.
  always_comb begin
    if (MSB_FIRST) in_word = {in_sr_reg, txda};
    else           in_word = {txda, in_sr_reg};
  end

  assign in_last = (in_bit_reg == BW'(DATA_WIDTH - 1));
  assign wr_req  = txen && in_last;
  // A full buffer still takes a word when a pop frees a slot on the same edge.
  assign wr_ok   = wr_req && ((count < CW'(DEPTH)) || pop);

  assign last_slot = (slot_reg == SW'(SLOTS - 1));
  assign advance   = (state_reg == SHIFT) && rx_ready && !last_slot;
  assign cur_bit   = MSB_FIRST ? out_sr_reg[DATA_WIDTH-1] : out_sr_reg[0];

  // Deserialiser: shift on txen, wrap the bit counter after the last bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_sr_reg  <= '0;
      in_bit_reg <= '0;
    end else if (txen) begin
      in_sr_reg  <= MSB_FIRST ? in_word[DATA_WIDTH-2:0] : in_word[DATA_WIDTH-1:1];
      in_bit_reg <= in_last ? '0 : in_bit_reg + BW'(1);
    end
  end

  // Ring pointers: write side on accepted words, read side on pops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

  // Storage with registered read straight into the output shift register.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr_reg] <= in_word;
    if (pop)
      out_sr_reg <= mem[rd_ptr_reg];
    else if (advance)
      out_sr_reg <= MSB_FIRST ? (out_sr_reg << 1) : (out_sr_reg >> 1);
  end

  // Serialiser state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Serialiser next state and pop decision.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty && rx_ready) begin
          pop        = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (rx_ready && last_slot) begin
          if (!empty) pop        = 1'b1;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Slot counter and framing; everything holds while rx_ready is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_reg  <= '0;
      txc       <= 1'b0;
      outstrobe <= 1'b0;
    end else if (pop) begin
      slot_reg  <= '0;
      txc       <= 1'b1;
      outstrobe <= 1'b0;
    end else if (state_reg == SHIFT && rx_ready) begin
      if (last_slot) begin
        slot_reg  <= '0;
        txc       <= 1'b0;
        outstrobe <= 1'b0;
      end else begin
        slot_reg  <= slot_reg + SW'(1);
        outstrobe <= (slot_reg == SW'(SLOTS - 2));
      end
    end
  end

`ifdef RINGBUF_PARITY_EN
  logic par_acc_reg;

  // Running XOR of the bits already sent; complete when the parity slot is reached.
  always_ff @(posedge clock) begin
    if (pop)          par_acc_reg <= 1'b0;
    else if (advance) par_acc_reg <= par_acc_reg ^ cur_bit;
  end

  assign rxda = txc && ((slot_reg == SW'(DATA_WIDTH)) ? par_acc_reg : cur_bit);
`else
  assign rxda = txc && cur_bit;
`endif

  // Occupancy bookkeeping.
  always_comb begin
    count_next = count;
    case ({wr_ok, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Registered status flags derived from the next occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      count       <= count_next;
      empty       <= (count_next == '0);
      full        <= (count_next == CW'(DEPTH));
      almost_full <= (count_next >= CW'(AFULL_LVL));
      if (wr_req && !wr_ok) overflow <= 1'b1;
    end
  end

endmodule
